// File: rtl/ft2232_tx_arbiter.sv
// Round-robin framer sharing the FT2232 TX byte path: header {sel,len}, then len+1 payload bytes.
// Latency: header 1 cycle after req is sampled, payload is a zero-latency pass-through; tx_ready_i backpressures every byte.
module ft2232_tx_arbiter #(
    parameter int unsigned TIMEOUT_CLKS = 255,
    parameter logic [7:0]  PAD_BYTE     = 8'h00
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       ch0_req_i,
    input  logic [6:0] ch0_len_i,
    output logic       ch0_gnt_o,
    input  logic [7:0] ch0_data_i,
    input  logic       ch0_valid_i,
    output logic       ch0_ready_o,
    input  logic       ch1_req_i,
    input  logic [6:0] ch1_len_i,
    output logic       ch1_gnt_o,
    input  logic [7:0] ch1_data_i,
    input  logic       ch1_valid_i,
    output logic       ch1_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       busy_o,
    output logic       underrun_o,
    output logic       pkt_done_o
);
    typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_PAYLOAD} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CLKS - 1);

    state_t     state;
    logic       sel;
    logic       last_grant;
    logic       pad_mode;
    logic [6:0] remaining;
    logic [7:0] header;
    logic [7:0] tmo_cnt;

    logic       src_vld;
    logic [7:0] src_dat;
    logic       grant_any;
    logic       grant_sel;
    logic [6:0] grant_len;
    logic       xfer;

    assign src_vld   = sel ? ch1_valid_i : ch0_valid_i;
    assign src_dat   = sel ? ch1_data_i  : ch0_data_i;
    assign grant_any = ch0_req_i | ch1_req_i;
    // On a tie the channel that did not win last time goes next.
    assign grant_sel = (ch0_req_i & ch1_req_i) ? ~last_grant : ch1_req_i;
    assign grant_len = grant_sel ? ch1_len_i : ch0_len_i;

    always_comb begin
        tx_data_o   = 8'h00;
        tx_valid_o  = 1'b0;
        ch0_ready_o = 1'b0;
        ch1_ready_o = 1'b0;
        case (state)
            ST_HEADER: begin
                tx_valid_o = 1'b1;
                tx_data_o  = header;
            end
            ST_PAYLOAD: begin
                if (pad_mode) begin
                    tx_valid_o = 1'b1;
                    tx_data_o  = PAD_BYTE;
                end else begin
                    tx_valid_o  = src_vld;
                    tx_data_o   = src_dat;
                    ch0_ready_o = ~sel & tx_ready_i;
                    ch1_ready_o = sel & tx_ready_i;
                end
            end
            default: ;
        endcase
    end

    assign xfer       = tx_valid_o & tx_ready_i;
    assign busy_o     = (state != ST_IDLE);
    assign pkt_done_o = (state == ST_PAYLOAD) && xfer && (remaining == 7'd0);
    // Flags the last idle cycle before padding takes over the rest of the packet.
    assign underrun_o = (state == ST_PAYLOAD) && !pad_mode && !src_vld && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state      <= ST_IDLE;
            sel        <= 1'b0;
            last_grant <= 1'b1;
            pad_mode   <= 1'b0;
            remaining  <= 7'd0;
            header     <= 8'h00;
            tmo_cnt    <= 8'h00;
            ch0_gnt_o  <= 1'b0;
            ch1_gnt_o  <= 1'b0;
        end else begin
            ch0_gnt_o <= 1'b0;
            ch1_gnt_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        sel        <= grant_sel;
                        last_grant <= grant_sel;
                        remaining  <= grant_len;
                        header     <= {grant_sel, grant_len};
                        ch0_gnt_o  <= ~grant_sel;
                        ch1_gnt_o  <= grant_sel;
                        pad_mode   <= 1'b0;
                        tmo_cnt    <= 8'h00;
                        state      <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (xfer) begin
                        tmo_cnt <= 8'h00;
                        state   <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (xfer) begin
                        if (remaining == 7'd0) begin
                            pad_mode <= 1'b0;
                            state    <= ST_IDLE;
                        end else begin
                            remaining <= remaining - 7'd1;
                        end
                    end
                    if (!pad_mode) begin
                        if (src_vld) begin
                            tmo_cnt <= 8'h00;
                        end else if (underrun_o) begin
                            tmo_cnt  <= 8'h00;
                            pad_mode <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + 8'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
